// File: rtl/cic_comp_fir_if.sv
// Bus between the CIC decimator and the compensation FIR.
// It carries the sample strobe in and the filtered strobe, status and debug state out.
interface cic_comp_fir_if #(
   parameter int IN_WIDTH  = 28,
   parameter int OUT_WIDTH = 16
);
   // Strobe semantics: in_valid is a one-cycle qualifier for in_data/decimation_factor.
   // There is no ready signal. A strobe that cannot be taken is dropped and raises the sticky overrun flag.
   // out_valid pulses for one cycle when out_data changes. out_data holds between pulses.
   logic signed [IN_WIDTH-1:0]  in_data;
   logic                        in_valid;
   logic [4:0]                  decimation_factor;
   logic signed [OUT_WIDTH-1:0] out_data;
   logic                        out_valid;
   logic                        busy;
   logic                        overrun;
   logic [1:0]                  fsm_state;

   modport master (
      output in_data, in_valid, decimation_factor,
      input  out_data, out_valid, busy, overrun, fsm_state
   );
   modport slave (
      input  in_data, in_valid, decimation_factor,
      output out_data, out_valid, busy, overrun, fsm_state
   );
endinterface

// File: rtl/cic_comp_fir.sv
// Removes the CIC gain D^3 with a rounded shift and saturates the result to 16 bits.
// It then applies an 11-tap symmetric compensation FIR using one time-shared multiplier.
module cic_comp_fir #(
   parameter int IN_WIDTH  = 28,
   parameter int OUT_WIDTH = 16
) (
   input logic           clk,
   input logic           rst,
   cic_comp_fir_if.slave bus
);
   localparam int ACC_W = 36;
   localparam int FRAC  = 14;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_MAC  = 2'd2;
   localparam logic [1:0] S_OUT  = 2'd3;

   localparam logic signed [IN_WIDTH:0] N_MAX =
      {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [IN_WIDTH:0] N_MIN =
      {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] O_MAX =
      {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] O_MIN =
      {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] O_HALF = ACC_W'(1) << (FRAC - 1);

   logic [1:0]                  state;
   logic [3:0]                  idx;
   logic signed [ACC_W-1:0]     acc;
   logic signed [OUT_WIDTH-1:0] x [0:10];
   logic signed [OUT_WIDTH-1:0] norm_reg;
   logic                        norm_full;
   logic                        accept;

   logic [2:0]                  k;
   logic [3:0]                  s;
   logic signed [IN_WIDTH:0]    n_rnd, n_sum, n_shift;
   logic signed [OUT_WIDTH-1:0] n_sat;

   // The shift amount is s = 3*log2(D). Any unsupported D passes the sample through unshifted.
   always_comb begin
      case (bus.decimation_factor)
         5'd2:    k = 3'd1;
         5'd4:    k = 3'd2;
         5'd8:    k = 3'd3;
         5'd16:   k = 3'd4;
         default: k = 3'd0;
      endcase
      s       = 4'(k) * 4'd3;
      n_rnd   = (s == 4'd0) ? '0 : ((IN_WIDTH+1)'(1) << (s - 4'd1));
      n_sum   = {bus.in_data[IN_WIDTH-1], bus.in_data} + n_rnd;
      n_shift = n_sum >>> s;
      if (n_shift > N_MAX)      n_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (n_shift < N_MIN) n_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                      n_sat = n_shift[OUT_WIDTH-1:0];
   end

   logic signed [OUT_WIDTH-1:0] tap_a, tap_b, coef;
   logic signed [OUT_WIDTH:0]   pre;
   logic signed [32:0]          prod;
   logic signed [ACC_W-1:0]     acc_next, o_rnd, o_shift;
   logic signed [OUT_WIDTH-1:0] o_sat;

   // Steps 0..4 fold the symmetric tap pairs. Step 5 takes the centre tap alone.
   always_comb begin
      tap_a = x[idx];
      tap_b = (idx == 4'd5) ? '0 : x[4'd10 - idx];
      case (idx)
         4'd0:    coef = -16'sd40;
         4'd1:    coef = 16'sd120;
         4'd2:    coef = -16'sd300;
         4'd3:    coef = 16'sd700;
         4'd4:    coef = -16'sd1500;
         default: coef = 16'sd18424;
      endcase
      pre      = {tap_a[OUT_WIDTH-1], tap_a} + {tap_b[OUT_WIDTH-1], tap_b};
      prod     = 33'(pre) * 33'(coef);
      acc_next = acc + ACC_W'(prod);
      o_rnd    = acc + O_HALF;
      o_shift  = o_rnd >>> FRAC;
      if (o_shift > O_MAX)      o_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else if (o_shift < O_MIN) o_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else                      o_sat = o_shift[OUT_WIDTH-1:0];
   end

   // OUT only registers the finished result, so a sample may be taken on that same edge.
   assign accept = bus.in_valid && !norm_full && (state == S_IDLE || state == S_OUT);
   assign bus.fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         idx           <= '0;
         acc           <= '0;
         norm_reg      <= '0;
         norm_full     <= 1'b0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.overrun   <= 1'b0;
         for (int i = 0; i < 11; i++) x[i] <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         if (bus.in_valid && !accept) bus.overrun <= 1'b1;
         if (accept) begin
            norm_reg  <= n_sat;
            norm_full <= 1'b1;
         end
         case (state)
            S_IDLE: if (accept) state <= S_LOAD;
            S_LOAD: begin
               x[0] <= norm_reg;
               for (int i = 1; i < 11; i++) x[i] <= x[i-1];
               norm_full <= 1'b0;
               acc       <= '0;
               idx       <= '0;
               bus.busy  <= 1'b1;
               state     <= S_MAC;
            end
            S_MAC: begin
               acc <= acc_next;
               idx <= idx + 4'd1;
               if (idx == 4'd5) state <= S_OUT;
            end
            S_OUT: begin
               bus.out_data  <= o_sat;
               bus.out_valid <= 1'b1;
               bus.busy      <= 1'b0;
               state         <= accept ? S_LOAD : S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
